// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative HI/LO multiply/divide unit; define MULDIV_SIGNED_EN to enable signed MULT/DIV
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, quo, rem;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d, negq_q, negq_d, negr_q, negr_d;
  logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic a_neg, b_neg, accept, dbz;
  logic [WIDTH:0] msum, dsub;
`ifdef MULDIV_SIGNED_EN
  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign prod  = negq_q ? -acc_q : acc_q;
  assign quo   = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem   = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
  logic unused_sign;
  assign unused_sign = ^{op[0], negq_q, negr_q};
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign a_mag = a;
  assign b_mag = b;
  assign prod  = acc_q;
  assign quo   = acc_q[WIDTH-1:0];
  assign rem   = acc_q[2*WIDTH-1:WIDTH];
`endif
  assign accept = start & (state_q == IDLE || state_q == DONE);
  assign msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign dsub   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
  assign dbz    = b_q == '0;
  // next-state: operand capture, one shift-add/restoring step per CALC cycle, sign fix and result write
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = CALC;
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          cnt_d   = CW'(WIDTH-1);
          div_d   = op[1];
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          a_d     = a;
          b_d     = b_mag;
          acc_d   = {{WIDTH{1'b0}}, a_mag};
        end else begin
          hi_d = wr_hi ? wr_data : hi_q;
          lo_d = wr_lo ? wr_data : lo_q;
        end
      end
      CALC: begin
        acc_d   = !div_q ? {msum, acc_q[WIDTH-1:1]}
                : dsub[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                : {dsub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        cnt_d   = cnt_q - CW'(1);
        state_d = cnt_q == '0 ? FIX : CALC;
      end
      default: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = div_q & dbz;
        hi_d    = !div_q ? prod[2*WIDTH-1:WIDTH] : dbz ? a_q : rem;
        lo_d    = !div_q ? prod[WIDTH-1:0] : dbz ? '1 : quo;
      end
    endcase
  end
  // state and result registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Parametrised iterative multiply/divide unit for the MIPS core, providing the HI/LO register pair behind MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It sits beside the single-cycle ALU and its `alucontrol` decoder. The datapath starts an operation with a one-cycle `start` pulse, watches `busy`, and reads `hi`/`lo` after `done`. One result bit is produced per cycle, so latency scales with `WIDTH`.

## Interface
- `WIDTH`, default 32: operand, HI and LO width; must be ≥ 4 and even.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: start request; sampled only in IDLE.
- `op` input 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a` input WIDTH: multiplicand or dividend; captured on accepted `start`.
- `b` input WIDTH: multiplier or divisor; captured on accepted `start`.
- `wr_hi` input 1: MTHI strobe; honoured only in IDLE.
- `wr_lo` input 1: MTLO strobe; honoured only in IDLE.
- `wr_data` input WIDTH: data for MTHI/MTLO.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse marking `hi`/`lo` valid with a new result.
- `div_by_zero` output 1: set with `done` when a divide had `b == 0`; held until the next accepted `start`.
- `hi` output WIDTH: HI register, which holds the upper product or the remainder.
- `lo` output WIDTH: LO register, which holds the lower product or the quotient.

## Operation
- FSM states:
  - IDLE: accept `start` or MTHI/MTLO writes.
  - CALC: WIDTH iterations.
  - FIX: sign correction and result write.
  - DONE: `done` pulse, then return to IDLE.
- Operand capture on accepted `start`:
  - Latch `op` and the operands.
  - For signed ops, latch operand magnitudes plus the result sign bits.
  - Clear `div_by_zero`.
  - Load the iteration counter with WIDTH-1.
- Multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per CALC cycle. FIX negates the product if exactly one signed operand was negative.
- Divide: restoring division, one quotient bit per CALC cycle.
  - The quotient is truncated toward zero.
  - The remainder takes the sign of the dividend.
  - The most negative value divided by -1 gives LO = most negative value and HI = 0. No trap is raised.
- Divide by zero:
  - The algorithm runs for the full latency.
  - The result is forced to HI = `a` as captured and LO = all ones, ignoring sign.
  - `div_by_zero` = 1.
- MTHI/MTLO in IDLE: `hi` or `lo` takes `wr_data` next cycle. Both strobes may be asserted together.
- Simultaneous `start` and `wr_*` in IDLE: `start` wins and the writes are dropped.
- While busy: `start`, `wr_hi` and `wr_lo` are ignored without error. `hi`/`lo` keep their old values until FIX.

## Timing
- Reset values: `busy` = 0, `done` = 0, `div_by_zero` = 0, `hi` = 0, `lo` = 0, FSM in IDLE. Reset mid-operation abandons the operation and writes no partial result.
- Cycle numbering takes the `start` acceptance cycle as cycle 0.
- Cycles 1 … WIDTH+1: `busy` = 1, covering WIDTH CALC cycles plus FIX.
- Cycle WIDTH+2:
  - `busy` = 0.
  - `done` = 1 for exactly one cycle.
  - `hi`/`lo`/`div_by_zero` show the new result.
  - `start` is accepted in this cycle, so back-to-back operations are WIDTH+2 cycles apart.
- `hi`/`lo` hold their value until the next FIX or MTHI/MTLO.
- A write in IDLE is visible on `hi`/`lo` in the next cycle.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - MULT and DIV perform two's-complement signed operations as described above.
  - Magnitude and negation logic is present.
- `MULDIV_SIGNED_EN` undefined:
  - `op[0]` is ignored, so MULT behaves as MULTU and DIV behaves as DIVU.
  - The FIX state still takes its cycle, so latency is unchanged.
  - All negation logic is removed.

## Test plan
- MULTU, WIDTH=32, `a`=`b`=0xFFFFFFFF: `done` in cycle 34, `hi`=0xFFFFFFFE, `lo`=0x00000001, `busy` high for cycles 1–33.
- MULT, -3 × 5 (`a`=0xFFFFFFFD, `b`=5): `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Without the macro, `hi`=0x00000004, `lo`=0xFFFFFFF1.
- DIV, -7 ÷ 2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU, 100 ÷ 7: `lo`=14, `hi`=2, `div_by_zero`=0.
- DIVU, 100 ÷ 0: `done` in cycle 34, `div_by_zero`=1, `hi`=0x00000064, `lo`=0xFFFFFFFF. The next accepted `start` clears the flag in cycle 1.
- Writes while busy, then in IDLE:
  - `start` held high and `wr_hi`=1 with 0x1234 during `busy`: both are ignored and exactly one `done` occurs.
  - Then `wr_lo`=1 with 0xCAFE in IDLE: `lo`=0xCAFE next cycle, `hi` unchanged.
- Reset mid-operation:
  - `rst_n`=0 at cycle 10 of a DIV: next cycle all outputs are 0 and no `done` follows.
  - Releasing reset and issuing a new `start`: `done` comes after WIDTH+2 cycles.
